// File: rtl/if_axi_rd_bridge.sv
// SRAM-like IF fetch port to single-beat AXI4 read master, in-order returns; if_data_ok one cycle after R beat.
// Backpressure: if_addr_ok held low while AR stalls (arvalid && !arready) or MAX_OUTSTANDING fetches are in flight.
module if_axi_rd_bridge #(
  parameter int         MAX_OUTSTANDING = 2,
  parameter logic [3:0] AXI_ID          = 4'd0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] if_addr,
  input  logic [3:0]  if_ben,
  output logic        if_addr_ok,
  output logic        if_data_ok,
  output logic [31:0] if_rdata,
  output logic        if_rerr,
  output logic        proto_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  logic [2:0] count;
  logic       req;
  logic       beat;
  logic       complete;
  logic       unused_rid;

  assign arid    = AXI_ID;
  assign arlen   = 8'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign rready  = 1'b1;

  // Single ID means the slave returns in order; rid carries no information.
  assign unused_rid = ^rid;

  assign req        = (if_ben != 4'b0000);
  assign if_addr_ok = req && (!arvalid || arready) && (count < 3'(MAX_OUTSTANDING));
  assign beat       = rvalid && rlast;
  assign complete   = beat && (count != 3'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      arvalid <= 1'b0;
      araddr  <= 32'd0;
    end else if (if_addr_ok) begin
      arvalid <= 1'b1;
      araddr  <= if_addr;
    end else if (arready) begin
      arvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= 3'd0;
    end else begin
      case ({if_addr_ok, complete})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Beats with nothing outstanding are dropped and flagged until reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      if_data_ok <= 1'b0;
      if_rdata   <= 32'd0;
      if_rerr    <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      if_data_ok <= complete;
      if_rerr    <= complete && (rresp != 2'b00);
      if (complete) begin
        if_rdata <= rdata;
      end
      if (beat && (count == 3'd0)) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule
